adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit fulladder slice (ports a,b,s,cin,cout) to add
//  or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
//  Carry is held in a register between slices. Valid/ready on both the operand
//  and result sides so it sits between a requester and a result consumer.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 8
//  (localparam NSLICE = WIDTH/4; slice counter width = $clog2(NSLICE))
// PORTS
//  clk        in   1      clock; all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/sub valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: compute a-b; 0: compute a+b
//  out_valid  out  1      sum/cout/ovf valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, two's complement, modulo 2^WIDTH
//  cout       out  1      carry out of MSB slice (sub: 1 = no borrow)
//  ovf        out  1      signed overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (any state, incl. mid-op): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   sum=0, cout=0, ovf=0, carry reg=0, slice idx=0; in-flight op discarded.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On edge with in_valid=1: latch a_r=a, b_r = sub ? ~b : b,
//   carry=sub, idx=0, sum=0, go RUN. in_valid=0: stay.
//  RUN: fulladder driven with a_r[4*idx+:4], b_r[4*idx+:4], cin=carry. Each edge:
//   sum[4*idx+:4]<=s, carry<=cout, idx<=idx+1. When idx==NSLICE-1: also
//   cout<=slice cout, ovf<=(a_r[W-1]==b_r[W-1]) && (s[3]!=a_r[W-1]), go DONE.
//   in_valid/a/b/sub ignored in RUN.
//  DONE: out_valid=1; sum/cout/ovf held stable. On edge with out_ready=1: go
//   IDLE (out_valid falls). out_ready=0: stay indefinitely (backpressure).
//  Latency: out_valid rises exactly NSLICE edges after the accepting edge
//   (WIDTH=16: 4 cycles). No overlap: in_ready low from accept until the cycle
//   after result handshake; min initiation interval NSLICE+2 cycles.
//  sum is partially updated during RUN; consumers sample only when out_valid=1.
//  Outputs sum/cout/ovf keep last result through IDLE until next accept.
//  in_ready, out_valid, busy decoded from state register only (no combinational
//   path from in_valid/out_ready).
// TESTING (WIDTH=16; out_ready=1 unless stated)
//  1 a=0x0033 b=0x0033 sub=0 -> sum=0x0066 cout=0 ovf=0; out_valid 4 cycles after
//    accept, in_ready=0 throughout.
//  2 a=0xFFFF b=0x0001 sub=0 -> sum=0x0000 cout=1 ovf=0 (carry through all slices);
//    a=0x7FFF b=0x0001 sub=0 -> sum=0x8000 cout=0 ovf=1.
//  3 a=0x0005 b=0x0007 sub=1 -> sum=0xFFFE cout=0 ovf=0; a=0x8000 b=0x0001 sub=1
//    -> sum=0x7FFF cout=1 ovf=1.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1, sum/cout/ovf
//    constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
//  5 reset=1 for one edge while idx=2 of a=0x1234+0x1111 -> next cycle IDLE,
//    in_ready=1, out_valid=0, sum=0; following op 0x1234+0x1111 -> sum=0x2345.
//  6 Back-to-back: in_valid held high with 3 operand sets -> each accepted only in
//    IDLE, results in order, exactly one out_valid handshake per accept.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit full-adder slice is reused
// WIDTH/4 times, LSB nibble first, with valid/ready on operand and result sides.

module fulladder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s       = w_total[3:0];
  assign cout    = w_total[4];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = $clog2(NSLICE);

  // Handshake rules: an operand transfer happens on a rising edge where
  // in_valid && in_ready; a result transfer on an edge where out_valid && out_ready.
  // Neither ready/valid output depends combinationally on the other side.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_slice;
  logic [3:0]       w_b_slice;
  logic [3:0]       w_s;
  logic             w_slice_cout;
  logic             w_last;
  logic             w_accept;
  logic             w_release;

  assign w_a_slice = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_slice = r_b[{r_idx, 2'b00} +: 4];
  assign w_last    = (r_idx == IDXW'(NSLICE - 1));
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_release = (r_state == S_DONE) && out_ready;

  fulladder u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the inversion is latched and the +1 enters as carry-in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_s;
      r_carry                    <= w_slice_cout;
      r_idx                      <= r_idx + IDXW'(1);
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

  logic w_unused;
  assign w_unused = w_release;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WIDTH=16) using immediate assertions.

module tb_adder_seq_ctrl;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH+1:0] exp_q[$];

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation from IDLE and check latency, flags and result.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_sub, input logic [15:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    a = op_a; b = op_b; sub = op_sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_out_valid_run"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      step();
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    step();
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_held_sum"}, 32'(sum), 32'(e_sum));
  endtask

  initial begin
    int accepted;
    int handshakes;
    int k;
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic        vs[3];
    logic [17:0] ve[3];
    logic [17:0] got;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    step();
    check("idle_hold_state", 32'(dbg_state), 32'd0);

    run_op("t1_add", 16'h0033, 16'h0033, 1'b0, 16'h0066, 1'b0, 1'b0);
    run_op("t2_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t3_sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("t3_subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // backpressure in DONE
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h0F0F; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 5; i++) begin
      check("t4_out_valid", 32'(out_valid), 32'd1);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_sum", 32'(sum), 32'h2143);
      check("t4_cout", 32'(cout), 32'd0);
      check("t4_ovf", 32'(ovf), 32'd0);
      in_valid = i[0];
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("t4_still_done", 32'(dbg_state), 32'd2);
    check("t4_sum_after_pulses", 32'(sum), 32'h2143);
    out_ready = 1'b1;
    step();
    check("t4_released_in_ready", 32'(in_ready), 32'd1);
    check("t4_released_out_valid", 32'(out_valid), 32'd0);
    check("t4_sum_kept", 32'(sum), 32'h2143);

    // reset mid-operation at idx==2
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t5_partial_sum", 32'(sum), 32'h0045);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    run_op("t5_after", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // back-to-back with in_valid held high; expected {ovf,cout,sum}
    va[0] = 16'h00FF; vb[0] = 16'h0001; vs[0] = 1'b0; ve[0] = {1'b0, 1'b0, 16'h0100};
    va[1] = 16'hABCD; vb[1] = 16'h1234; vs[1] = 1'b1; ve[1] = {1'b0, 1'b1, 16'h9999};
    va[2] = 16'h4000; vb[2] = 16'h4000; vs[2] = 1'b0; ve[2] = {1'b1, 1'b0, 16'h8000};
    accepted = 0; handshakes = 0;
    a = va[0]; b = vb[0]; sub = vs[0]; in_valid = 1'b1;
    k = 0;
    while (k < 60 && handshakes < 3) begin
      if (in_ready && out_valid) check("t6_overlap", 32'd1, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t6_unexpected_result", 32'd1, 32'd0);
        end else begin
          got = {ovf, cout, sum};
          check("t6_result", 32'(got), 32'(exp_q.pop_front()));
        end
        handshakes++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(ve[accepted]);
        accepted++;
      end
      step();
      if (accepted < 3) begin
        a = va[accepted]; b = vb[accepted]; sub = vs[accepted];
      end else begin
        in_valid = 1'b0;
      end
      k++;
    end
    check("t6_handshakes", 32'(handshakes), 32'd3);
    check("t6_accepted", 32'(accepted), 32'd3);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_idle_end", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
